// File: rtl/core_data_demux_pkg.sv
// rtl/core_data_demux_pkg.sv - shared types and mailbox addresses for the core data demux
//
// Purpose : target identifiers and mailbox address constants used by the
//           demux top and its outstanding-transaction FIFO.
// Contents: tgt_e   - 2-bit target id (periph, stack, tcdm, sink)
//           EXIT_ADDR, PUTC_ADDR - mailbox register addresses
package core_data_demux_pkg;

  typedef enum logic [1:0] {
    TGT_PERIPH = 2'd0,
    TGT_STACK  = 2'd1,
    TGT_TCDM   = 2'd2,
    TGT_SINK   = 2'd3
  } tgt_e;

  localparam logic [31:0] EXIT_ADDR = 32'h8000_0000;
  localparam logic [31:0] PUTC_ADDR = 32'h8000_0004;

endpackage

// File: rtl/core_data_demux_id_fifo.sv
// rtl/core_data_demux_id_fifo.sv - in-order FIFO of target ids for outstanding transactions
//
// Purpose : remembers which target each granted request went to, so that
//           responses can be steered back in issue order.
// Ports   : clk_i, rst_ni      clock, async active-low reset
//           push, push_id      enqueue a target id
//           pop                dequeue the head entry
//           head, tail         oldest / most recently pushed id
//           full, empty, count occupancy status
// Push and pop may occur in the same cycle, including when full.
module core_data_demux_id_fifo
  import core_data_demux_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           push,
  input  tgt_e                           push_id,
  input  logic                           pop,
  output tgt_e                           head,
  output tgt_e                           tail,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  tgt_e          mem_q [DEPTH];
  tgt_e          tail_q;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  assign head  = mem_q[rd_ptr_q];
  assign tail  = tail_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= TGT_PERIPH;
      end
      tail_q   <= TGT_PERIPH;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // When full and popping, wr_ptr equals rd_ptr: the slot being
      // vacated is overwritten at the same edge, which is safe.
      if (push) begin
        mem_q[wr_ptr_q] <= push_id;
        tail_q          <= push_id;
        wr_ptr_q        <= (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/core_data_demux.sv
// rtl/core_data_demux.sv - core data port demux with in-order response steering and mailbox
//
// Purpose : routes core data requests to periph / stack / tcdm targets or the
//           built-in mailbox sink, and returns responses in issue order.
// Ports   : clk_i, rst_ni                 clock, async active-low reset
//           data_*                        core data port (req/gnt/rvalid)
//           tgt_req_o/tgt_gnt_i           per-target handshake (0 periph, 1 stack, 2 tcdm)
//           tgt_add/wen/be/data_o         broadcast request fields
//           tgt_rvalid_i/tgt_rdata_i      per-target responses
//           exit_valid_o, exit_code_o     exit mailbox (sticky)
//           char_valid_o, char_o          putchar mailbox (one-cycle pulse)
//           outstanding_o                 outstanding transaction count
//           proto_err_o                   sticky unexpected-rvalid flag
module core_data_demux
  import core_data_demux_pkg::*;
#(
  parameter int unsigned HWPE_ADDR_BASE_BIT = 20,
  parameter int unsigned MAX_OUTSTANDING    = 2,
  parameter logic [7:0]  SINK_TOP_BYTE      = 8'h80
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   data_req_i,
  output logic                                   data_gnt_o,
  input  logic                                   data_we_i,
  input  logic [3:0]                             data_be_i,
  input  logic [31:0]                            data_addr_i,
  input  logic [31:0]                            data_wdata_i,
  output logic                                   data_rvalid_o,
  output logic [31:0]                            data_rdata_o,
  output logic [2:0]                             tgt_req_o,
  input  logic [2:0]                             tgt_gnt_i,
  output logic [31:0]                            tgt_add_o,
  output logic                                   tgt_wen_o,
  output logic [3:0]                             tgt_be_o,
  output logic [31:0]                            tgt_data_o,
  input  logic [2:0]                             tgt_rvalid_i,
  input  logic [2:0][31:0]                       tgt_rdata_i,
  output logic                                   exit_valid_o,
  output logic [31:0]                            exit_code_o,
  output logic                                   char_valid_o,
  output logic [7:0]                             char_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic                                   proto_err_o
);

  tgt_e req_tgt;
  tgt_e head_tgt;
  tgt_e tail_tgt;
  logic fifo_full;
  logic fifo_empty;
  logic gate_open;
  logic push;
  logic pop;
  logic [2:0] expect_mask;

  logic        sink_rvalid_q;
  logic        exit_valid_q;
  logic [31:0] exit_code_q;
  logic        char_valid_q;
  logic [7:0]  char_q;
  logic        proto_err_q;

  assign tgt_add_o  = data_addr_i;
  assign tgt_wen_o  = ~data_we_i;
  assign tgt_be_o   = data_be_i;
  assign tgt_data_o = data_wdata_i;

  always_comb begin
    req_tgt = TGT_TCDM;
    if (data_addr_i[HWPE_ADDR_BASE_BIT]) begin
      req_tgt = TGT_PERIPH;
    end else if (data_addr_i[31:24] == SINK_TOP_BYTE) begin
      req_tgt = TGT_SINK;
    end else if (data_addr_i[31:24] == 8'h00) begin
      req_tgt = TGT_STACK;
    end
  end

  // Response side: only the head target may complete; anything else is a
  // protocol violation and is dropped.
  always_comb begin
    pop          = 1'b0;
    data_rdata_o = '0;
    expect_mask  = '0;
    if (!fifo_empty) begin
      case (head_tgt)
        TGT_PERIPH: begin
          pop          = tgt_rvalid_i[0];
          data_rdata_o = tgt_rdata_i[0];
          expect_mask  = 3'b001;
        end
        TGT_STACK: begin
          pop          = tgt_rvalid_i[1];
          data_rdata_o = tgt_rdata_i[1];
          expect_mask  = 3'b010;
        end
        TGT_TCDM: begin
          pop          = tgt_rvalid_i[2];
          data_rdata_o = tgt_rdata_i[2];
          expect_mask  = 3'b100;
        end
        default: begin
          pop          = sink_rvalid_q;
          data_rdata_o = '0;
        end
      endcase
    end
  end

  assign data_rvalid_o = pop;

  // Only one target kind in flight at a time, so differing target
  // latencies can never reorder responses.
  assign gate_open = (!fifo_full || pop) && (fifo_empty || (tail_tgt == req_tgt));

  always_comb begin
    tgt_req_o  = '0;
    data_gnt_o = 1'b0;
    if (gate_open) begin
      case (req_tgt)
        TGT_PERIPH: begin
          tgt_req_o[0] = data_req_i;
          data_gnt_o   = data_req_i & tgt_gnt_i[0];
        end
        TGT_STACK: begin
          tgt_req_o[1] = data_req_i;
          data_gnt_o   = data_req_i & tgt_gnt_i[1];
        end
        TGT_TCDM: begin
          tgt_req_o[2] = data_req_i;
          data_gnt_o   = data_req_i & tgt_gnt_i[2];
        end
        default: begin
          data_gnt_o = data_req_i;
        end
      endcase
    end
  end

  assign push = data_gnt_o;

  core_data_demux_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push    (push),
    .push_id (req_tgt),
    .pop     (pop),
    .head    (head_tgt),
    .tail    (tail_tgt),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (outstanding_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sink_rvalid_q <= 1'b0;
      exit_valid_q  <= 1'b0;
      exit_code_q   <= '0;
      char_valid_q  <= 1'b0;
      char_q        <= '0;
      proto_err_q   <= 1'b0;
    end else begin
      sink_rvalid_q <= push && (req_tgt == TGT_SINK);
      char_valid_q  <= 1'b0;
      if (push && (req_tgt == TGT_SINK) && data_we_i) begin
        if (data_addr_i == EXIT_ADDR) begin
          exit_valid_q <= 1'b1;
          exit_code_q  <= data_wdata_i;
        end
        if (data_addr_i == PUTC_ADDR) begin
          char_valid_q <= 1'b1;
          char_q       <= data_wdata_i[7:0];
        end
      end
      if (|(tgt_rvalid_i & ~expect_mask)) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  assign exit_valid_o = exit_valid_q;
  assign exit_code_o  = exit_code_q;
  assign char_valid_o = char_valid_q;
  assign char_o       = char_q;
  assign proto_err_o  = proto_err_q;

endmodule

// File: tb/tb_core_data_demux.sv
// tb/tb_core_data_demux.sv - directed self-checking bench for core_data_demux
module tb_core_data_demux;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            data_req_i;
  logic            data_gnt_o;
  logic            data_we_i;
  logic [3:0]      data_be_i;
  logic [31:0]     data_addr_i;
  logic [31:0]     data_wdata_i;
  logic            data_rvalid_o;
  logic [31:0]     data_rdata_o;
  logic [2:0]      tgt_req_o;
  logic [2:0]      tgt_gnt_i;
  logic [31:0]     tgt_add_o;
  logic            tgt_wen_o;
  logic [3:0]      tgt_be_o;
  logic [31:0]     tgt_data_o;
  logic [2:0]      tgt_rvalid_i;
  logic [2:0][31:0] tgt_rdata_i;
  logic            exit_valid_o;
  logic [31:0]     exit_code_o;
  logic            char_valid_o;
  logic [7:0]      char_o;
  logic [1:0]      outstanding_o;
  logic            proto_err_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  core_data_demux dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .data_req_i    (data_req_i),
    .data_gnt_o    (data_gnt_o),
    .data_we_i     (data_we_i),
    .data_be_i     (data_be_i),
    .data_addr_i   (data_addr_i),
    .data_wdata_i  (data_wdata_i),
    .data_rvalid_o (data_rvalid_o),
    .data_rdata_o  (data_rdata_o),
    .tgt_req_o     (tgt_req_o),
    .tgt_gnt_i     (tgt_gnt_i),
    .tgt_add_o     (tgt_add_o),
    .tgt_wen_o     (tgt_wen_o),
    .tgt_be_o      (tgt_be_o),
    .tgt_data_o    (tgt_data_o),
    .tgt_rvalid_i  (tgt_rvalid_i),
    .tgt_rdata_i   (tgt_rdata_i),
    .exit_valid_o  (exit_valid_o),
    .exit_code_o   (exit_code_o),
    .char_valid_o  (char_valid_o),
    .char_o        (char_o),
    .outstanding_o (outstanding_o),
    .proto_err_o   (proto_err_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    data_req_i   = 1'b0;
    data_we_i    = 1'b0;
    data_be_i    = 4'h0;
    data_addr_i  = '0;
    data_wdata_i = '0;
    tgt_gnt_i    = '0;
    tgt_rvalid_i = '0;
    tgt_rdata_i  = '0;
  endtask

  task automatic drive_req(input logic [31:0] addr, input logic we, input logic [31:0] wdata);
    data_req_i   = 1'b1;
    data_we_i    = we;
    data_be_i    = 4'hF;
    data_addr_i  = addr;
    data_wdata_i = wdata;
  endtask

  initial begin
    rst_ni = 1'b0;
    idle_inputs();
    step(); step();
    check("rst_outstanding", 32'(outstanding_o), 0);
    check("rst_gnt", 32'(data_gnt_o), 0);
    check("rst_rvalid", 32'(data_rvalid_o), 0);
    check("rst_tgt_req", 32'(tgt_req_o), 0);
    check("rst_exit_valid", 32'(exit_valid_o), 0);
    check("rst_exit_code", exit_code_o, 0);
    check("rst_char_valid", 32'(char_valid_o), 0);
    check("rst_proto_err", 32'(proto_err_o), 0);
    rst_ni = 1'b1;

    // tcdm read
    step();
    drive_req(32'h1C01_0000, 1'b0, '0);
    tgt_gnt_i = 3'b100;
    settle();
    check("tcdm_req", 32'(tgt_req_o), 32'b100);
    check("tcdm_gnt", 32'(data_gnt_o), 1);
    check("tcdm_wen", 32'(tgt_wen_o), 1);
    step();
    idle_inputs();
    tgt_rvalid_i   = 3'b100;
    tgt_rdata_i[2] = 32'hDEAD_BEEF;
    settle();
    check("tcdm_outst1", 32'(outstanding_o), 1);
    check("tcdm_rvalid", 32'(data_rvalid_o), 1);
    check("tcdm_rdata", data_rdata_o, 32'hDEAD_BEEF);
    step();
    idle_inputs();
    settle();
    check("tcdm_outst0", 32'(outstanding_o), 0);
    check("tcdm_rvalid_off", 32'(data_rvalid_o), 0);

    // mailbox: putchar then exit
    drive_req(32'h8000_0004, 1'b1, 32'h0000_0041);
    settle();
    check("putc_gnt", 32'(data_gnt_o), 1);
    check("putc_tgt_req", 32'(tgt_req_o), 0);
    step();
    drive_req(32'h8000_0000, 1'b1, 32'h0000_0000);
    settle();
    check("putc_pulse", 32'(char_valid_o), 1);
    check("putc_char", 32'(char_o), 32'h41);
    check("putc_rvalid", 32'(data_rvalid_o), 1);
    check("putc_rdata", data_rdata_o, 0);
    check("exit_gnt", 32'(data_gnt_o), 1);
    check("exit_tgt_req", 32'(tgt_req_o), 0);
    step();
    idle_inputs();
    settle();
    check("putc_pulse_end", 32'(char_valid_o), 0);
    check("exit_valid", 32'(exit_valid_o), 1);
    check("exit_code", exit_code_o, 0);
    check("exit_rvalid", 32'(data_rvalid_o), 1);
    step();
    settle();
    check("sink_outst0", 32'(outstanding_o), 0);
    check("sink_rvalid_off", 32'(data_rvalid_o), 0);
    check("exit_sticky", 32'(exit_valid_o), 1);

    // back-to-back stack reads, FIFO fills, third stalls until a pop
    drive_req(32'h0000_1000, 1'b0, '0);
    tgt_gnt_i = 3'b010;
    settle();
    check("stk1_gnt", 32'(data_gnt_o), 1);
    step();
    data_addr_i = 32'h0000_1004;
    settle();
    check("stk2_gnt", 32'(data_gnt_o), 1);
    check("stk2_outst", 32'(outstanding_o), 1);
    step();
    data_addr_i = 32'h0000_1008;
    settle();
    check("stk_full", 32'(outstanding_o), 2);
    check("stk3_stall_gnt", 32'(data_gnt_o), 0);
    check("stk3_stall_req", 32'(tgt_req_o), 0);
    step();
    tgt_rvalid_i   = 3'b010;
    tgt_rdata_i[1] = 32'h1111_1111;
    settle();
    check("stk1_rvalid", 32'(data_rvalid_o), 1);
    check("stk1_rdata", data_rdata_o, 32'h1111_1111);
    check("stk3_pop_gnt", 32'(data_gnt_o), 1);
    check("stk3_pop_req", 32'(tgt_req_o), 32'b010);
    step();
    data_req_i     = 1'b0;
    tgt_rdata_i[1] = 32'h2222_2222;
    settle();
    check("stk_pushpop_outst", 32'(outstanding_o), 2);
    check("stk2_rdata", data_rdata_o, 32'h2222_2222);
    step();
    tgt_rdata_i[1] = 32'h3333_3333;
    settle();
    check("stk_outst1", 32'(outstanding_o), 1);
    check("stk3_rdata", data_rdata_o, 32'h3333_3333);
    step();
    idle_inputs();
    settle();
    check("stk_outst0", 32'(outstanding_o), 0);

    // periph outstanding blocks a stack request until it drains
    drive_req(32'h0010_0000, 1'b0, '0);
    tgt_gnt_i = 3'b011;
    settle();
    check("per_req", 32'(tgt_req_o), 32'b001);
    check("per_gnt", 32'(data_gnt_o), 1);
    step();
    data_addr_i = 32'h0000_2000;
    settle();
    check("per_blk_gnt", 32'(data_gnt_o), 0);
    check("per_blk_req", 32'(tgt_req_o), 0);
    step();
    tgt_rvalid_i   = 3'b001;
    tgt_rdata_i[0] = 32'hAAAA_5555;
    settle();
    check("per_rvalid", 32'(data_rvalid_o), 1);
    check("per_rdata", data_rdata_o, 32'hAAAA_5555);
    check("per_popblk_gnt", 32'(data_gnt_o), 0);
    step();
    tgt_rvalid_i = '0;
    settle();
    check("stk_after_gnt", 32'(data_gnt_o), 1);
    check("stk_after_req", 32'(tgt_req_o), 32'b010);
    step();
    data_req_i     = 1'b0;
    tgt_rvalid_i   = 3'b010;
    tgt_rdata_i[1] = 32'hBEEF_0001;
    settle();
    check("stk_after_rdata", data_rdata_o, 32'hBEEF_0001);
    step();
    idle_inputs();
    settle();
    check("per_outst0", 32'(outstanding_o), 0);
    check("no_err_yet", 32'(proto_err_o), 0);

    // stray rvalid with FIFO empty
    tgt_rvalid_i   = 3'b100;
    tgt_rdata_i[2] = 32'h5A5A_5A5A;
    settle();
    check("stray_rvalid", 32'(data_rvalid_o), 0);
    step();
    idle_inputs();
    settle();
    check("proto_err_set", 32'(proto_err_o), 1);
    drive_req(32'h1C00_0040, 1'b0, '0);
    tgt_gnt_i = 3'b100;
    step();
    idle_inputs();
    tgt_rvalid_i   = 3'b100;
    tgt_rdata_i[2] = 32'h0BAD_F00D;
    settle();
    check("err_traffic_rdata", data_rdata_o, 32'h0BAD_F00D);
    step();
    idle_inputs();
    settle();
    check("proto_err_sticky", 32'(proto_err_o), 1);

    // async reset with two outstanding
    drive_req(32'h0000_3000, 1'b0, '0);
    tgt_gnt_i = 3'b010;
    step();
    step();
    idle_inputs();
    settle();
    check("pre_rst_outst", 32'(outstanding_o), 2);
    rst_ni = 1'b0;
    #1;
    check("arst_outst", 32'(outstanding_o), 0);
    check("arst_proto_err", 32'(proto_err_o), 0);
    check("arst_exit_valid", 32'(exit_valid_o), 0);
    check("arst_rvalid", 32'(data_rvalid_o), 0);
    step();
    rst_ni = 1'b1;
    step();
    drive_req(32'h1C01_0010, 1'b0, '0);
    tgt_gnt_i = 3'b100;
    settle();
    check("post_rst_gnt", 32'(data_gnt_o), 1);
    step();
    idle_inputs();
    tgt_rvalid_i   = 3'b100;
    tgt_rdata_i[2] = 32'hC0FF_EE00;
    settle();
    check("post_rst_rdata", data_rdata_o, 32'hC0FF_EE00);
    check("post_rst_rvalid", 32'(data_rvalid_o), 1);
    step();
    idle_inputs();
    settle();
    check("post_rst_outst0", 32'(outstanding_o), 0);
    check("post_rst_no_err", 32'(proto_err_o), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/core_data_demux.md
Name: core_data_demux

Overview:
- Sits between the cv32e40p data port and the testbench/cluster data targets: HWPE peripheral port, stack memory, TCDM memory, and a built-in mailbox sink.
- Decodes each request, forwards it to one target, and tracks outstanding transactions in a small in-order FIFO.
- Steers responses back by FIFO head rather than by OR-ing rvalids.
- Implements the 0x8000_0000 mailbox (exit code, putchar) as registered outputs.

Parameters:
- HWPE_ADDR_BASE_BIT, 20, address bit selecting the HWPE peripheral target.
- MAX_OUTSTANDING, 2, depth of the outstanding-transaction FIFO (at least 1).
- SINK_TOP_BYTE, 8'h80, addr[31:24] value selecting the mailbox sink.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- data_req_i  in  1  core request
- data_gnt_o  out  1  grant to core
- data_we_i  in  1  core write enable (1 = write)
- data_be_i  in  4  byte enables
- data_addr_i  in  32  address
- data_wdata_i  in  32  write data
- data_rvalid_o  out  1  response valid to core
- data_rdata_o  out  32  response data to core
- tgt_req_o  out  3  per-target request; index 0 periph, 1 stack, 2 tcdm
- tgt_gnt_i  in  3  per-target grant
- tgt_add_o  out  32  broadcast address (= data_addr_i)
- tgt_wen_o  out  1  broadcast write-enable, active low (= ~data_we_i)
- tgt_be_o  out  4  broadcast byte enables
- tgt_data_o  out  32  broadcast write data
- tgt_rvalid_i  in  3  per-target response valid
- tgt_rdata_i  in  3x32  per-target response data
- exit_valid_o  out  1  sticky; exit code has been written
- exit_code_o  out  32  last value written to 0x8000_0000
- char_valid_o  out  1  one-cycle pulse on write to 0x8000_0004
- char_o  out  8  wdata[7:0] of that write
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  FIFO occupancy
- proto_err_o  out  1  sticky protocol error

Behaviour:
- Reset values: all outputs 0; FIFO empty.
- Decode, first match wins:
  - addr[HWPE_ADDR_BASE_BIT] = 1 -> periph.
  - addr[31:24] = SINK_TOP_BYTE -> sink.
  - addr[31:24] = 0 -> stack.
  - otherwise -> tcdm.
- Issue gate: a request may issue only if all of the following hold:
  - FIFO not full, or a pop occurs in the same cycle.
  - FIFO empty, or the tail (last pushed) target equals the new target. This prevents reordering between targets with different latencies.
- When the gate is closed: tgt_req_o = 0 and data_gnt_o = 0. The core holds its request stable.
- When the gate is open:
  - The decoded target's tgt_req_o = data_req_i.
  - data_gnt_o = that target's tgt_gnt_i; for the sink, data_gnt_o = 1 (combinational).
- Push: on a granted request, push the target id (2 bits) into the FIFO.
- Pop: when the head target's rvalid is 1.
  - data_rvalid_o = 1 and data_rdata_o = head target rdata, same cycle (combinational).
- Sink:
  - Responds exactly one cycle after grant with rdata 0.
  - Write to 0x8000_0000: exit_code_o <= wdata, exit_valid_o <= 1, registered one cycle after grant.
  - Write to 0x8000_0004: char_valid_o pulses the cycle after grant, with char_o = wdata[7:0].
  - Other sink addresses, and all sink reads: no side effect.
- Simultaneous push and pop: occupancy unchanged. Full plus pop still permits a push.
- rvalid from a non-head target, or any rvalid with the FIFO empty:
  - Ignored (not forwarded).
  - proto_err_o <= 1, sticky until reset.
- Reset mid-transaction: FIFO cleared. Late rvalids arriving after reset raise proto_err_o; the bench avoids this.
- Latency: zero added cycles on request and response paths; the mailbox registers add one cycle.

Decomposition:
- Shared package core_data_demux_pkg:
  - tgt_e enum (TGT_PERIPH = 0, TGT_STACK = 1, TGT_TCDM = 2, TGT_SINK = 3).
  - EXIT_ADDR = 32'h8000_0000.
  - PUTC_ADDR = 32'h8000_0004.
- One sub-module: core_data_demux_id_fifo.
  - Parameterised FIFO of tgt_e.
  - Provides head, tail, full, empty and count.
  - Supports same-cycle push and pop.

Test Plan:
- Read at 0x1C01_0000 with tcdm gnt = 1 and rvalid 1 cycle later carrying 0xDEAD_BEEF -> tgt_req_o = 3'b100; core sees gnt, then rvalid with rdata 0xDEAD_BEEF; outstanding_o goes 1 -> 0.
- Write 0x0000_0041 to 0x8000_0004, then 0x0000_0000 to 0x8000_0000 -> char_valid_o pulses once with char_o = 0x41; exit_valid_o = 1 and exit_code_o = 0; tgt_req_o stays 0.
- Back-to-back stack reads (MAX_OUTSTANDING = 2, stack rvalid 2 cycles late) -> two grants, outstanding_o reaches 2; a third request is stalled (gnt = 0) until the first rvalid, then granted in the pop cycle.
- Periph read outstanding, then stack request -> data_gnt_o = 0 and tgt_req_o[1] = 0 until the periph rvalid; the stack is then granted the next cycle.
- Inject tcdm rvalid with FIFO empty -> data_rvalid_o = 0 and proto_err_o = 1, held through later traffic.
- Assert rst_ni low with 2 outstanding -> all outputs 0 and outstanding_o = 0 immediately (asynchronously); a fresh read completes normally after reset.
